nvdla_bdma_mc_load: RTL and testbench

NVDLA_BDMA_MC_LOAD -- requirements
Module: nvdla_bdma_mc_load

---
 rtl/nvdla_bdma_mc_pkg.sv | 41 ++++
 rtl/nvdla_bdma_rr_arb.sv | 42 ++++
 rtl/nvdla_bdma_mc_load.sv | 226 ++++++++++++++++++++++
 tb/tb_nvdla_bdma_mc_load.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nvdla_bdma_mc_pkg.sv
// Shared types and constants for the multi-channel BDMA load engine.
// Struct fields are sized for the widest supported configuration; the top slices them down.
package nvdla_bdma_mc_pkg;

    localparam int ATOM_SHIFT = 5;
    localparam int PKG_AW     = 64;
    localparam int PKG_LSW    = 13;
    localparam int PKG_RPW    = 24;
    localparam int PKG_SW     = 27;
    localparam int PKG_ZW     = 4;
    localparam int PKG_CW     = 3;

    typedef enum logic {
        CH_IDLE   = 1'b0,
        CH_ACTIVE = 1'b1
    } ch_state_e;

    typedef struct packed {
        logic [PKG_AW-1:0]  src_addr;
        logic [PKG_AW-1:0]  dst_addr;
        logic [PKG_LSW-1:0] line_size;
        logic [PKG_RPW-1:0] line_num;
        logic [PKG_RPW-1:0] surf_num;
        logic [PKG_SW-1:0]  src_line_stride;
        logic [PKG_SW-1:0]  src_surf_stride;
        logic [PKG_SW-1:0]  dst_line_stride;
        logic [PKG_SW-1:0]  dst_surf_stride;
    } desc_t;

    typedef struct packed {
        logic              last;
        logic [PKG_ZW-1:0] size_m1;
        logic [PKG_AW-1:0] dst_addr;
        logic [PKG_CW-1:0] ch;
    } ld2st_ctx_t;

    function automatic logic [PKG_AW-1:0] atoms_to_bytes(input logic [PKG_SW-1:0] atoms);
        return PKG_AW'(atoms) << ATOM_SHIFT;
    endfunction

endpackage

// File: rtl/nvdla_bdma_rr_arb.sv
// Round-robin arbiter: searches from the pointer upward, pointer moves past each taken grant.
module nvdla_bdma_rr_arb #(
    parameter int NCH = 2,
    parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic [NCH-1:0] req_i,
    input  logic           adv_i,
    output logic           gnt_vld_o,
    output logic [CW-1:0]  gnt_idx_o
);

    logic [CW-1:0] ptr_q;
    logic [CW-1:0] ptr_d;
    int            idx;

    always_comb begin
        gnt_vld_o = 1'b0;
        gnt_idx_o = '0;
        idx       = 0;
        for (int i = 0; i < NCH; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NCH) idx = idx - NCH;
            if (!gnt_vld_o && req_i[idx]) begin
                gnt_vld_o = 1'b1;
                gnt_idx_o = CW'(idx);
            end
        end
    end

    always_comb begin
        if (int'(gnt_idx_o) == NCH - 1) ptr_d = '0;
        else                            ptr_d = gnt_idx_o + CW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)    ptr_q <= '0;
        else if (adv_i) ptr_q <= ptr_d;
    end

endmodule

// File: rtl/nvdla_bdma_mc_load.sv
// BDMA load engine: per-channel line/surface walkers feeding one shared request stage
// that drives the read request and the matching store context together.
module nvdla_bdma_mc_load
    import nvdla_bdma_mc_pkg::*;
#(
    parameter int NCH       = 2,
    parameter int AW        = 64,
    parameter int MAX_BURST = 8,
    parameter int LSW       = 13,
    parameter int RPW       = 24,
    parameter int SW        = 27,
    parameter int CW        = (NCH > 1) ? $clog2(NCH) : 1,
    parameter int ZW        = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
    input  logic                 nvdla_core_clk,
    input  logic                 nvdla_core_rstn,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CW-1:0]        cfg_ch,
    input  logic [AW-1:0]        cfg_src_addr,
    input  logic [AW-1:0]        cfg_dst_addr,
    input  logic [LSW-1:0]       cfg_line_size,
    input  logic [RPW-1:0]       cfg_line_num,
    input  logic [RPW-1:0]       cfg_surf_num,
    input  logic [SW-1:0]        cfg_src_line_stride,
    input  logic [SW-1:0]        cfg_src_surf_stride,
    input  logic [SW-1:0]        cfg_dst_line_stride,
    input  logic [SW-1:0]        cfg_dst_surf_stride,
    output logic                 rd_req_valid,
    input  logic                 rd_req_ready,
    output logic [AW+ZW-1:0]     rd_req_pd,
    output logic                 ld2st_valid,
    input  logic                 ld2st_ready,
    output logic [CW+AW+ZW:0]    ld2st_pd,
    output logic [NCH-1:0]       ch_idle,
    output logic [NCH-1:0]       stall_inc
);

    localparam logic [LSW:0] ONE_L   = (LSW+1)'(1);
    localparam logic [LSW:0] BURST_L = (LSW+1)'(MAX_BURST);

    ch_state_e      state_q    [NCH];
    desc_t          desc_q     [NCH];
    logic [LSW-1:0] off_q      [NCH];
    logic [RPW-1:0] line_q     [NCH];
    logic [RPW-1:0] surf_q     [NCH];
    logic [AW-1:0]  src_line_q [NCH];
    logic [AW-1:0]  src_surf_q [NCH];
    logic [AW-1:0]  dst_line_q [NCH];
    logic [AW-1:0]  dst_surf_q [NCH];

    logic [LSW:0]   rem_d      [NCH];
    logic [LSW:0]   size_d     [NCH];
    logic [AW-1:0]  src_addr_d [NCH];
    logic [AW-1:0]  dst_addr_d [NCH];
    logic [AW-1:0]  src_line_nxt_d [NCH];
    logic [AW-1:0]  src_surf_nxt_d [NCH];
    logic [AW-1:0]  dst_line_nxt_d [NCH];
    logic [AW-1:0]  dst_surf_nxt_d [NCH];
    logic [NCH-1:0] eol_d;
    logic [NCH-1:0] last_d;
    logic [NCH-1:0] elig_d;

    logic            stg_vld_q;
    logic [AW+ZW-1:0] stg_rd_pd_q;
    ld2st_ctx_t      stg_ctx_q;
    logic [CW-1:0]   stg_ch;

    logic            cfg_acc;
    desc_t           cfg_desc_d;
    logic            gnt_vld;
    logic [CW-1:0]   gnt_idx;
    logic            consume;
    logic            load;
    ld2st_ctx_t      gnt_ctx_d;
    logic [AW+ZW-1:0] gnt_rd_pd_d;
    logic            unused_bits;

    assign stg_ch  = stg_ctx_q.ch[CW-1:0];
    assign consume = stg_vld_q && rd_req_ready && ld2st_ready;
    assign load    = gnt_vld && (!stg_vld_q || consume);
    assign cfg_acc = cfg_valid && cfg_ready;

    // Per-channel view of the next request: size, end-of-line, final request, addresses.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            rem_d[c]      = {1'b0, desc_q[c].line_size[LSW-1:0]} - {1'b0, off_q[c]} + ONE_L;
            size_d[c]     = (rem_d[c] > BURST_L) ? BURST_L : rem_d[c];
            eol_d[c]      = (rem_d[c] <= BURST_L);
            last_d[c]     = eol_d[c] && (line_q[c] == desc_q[c].line_num[RPW-1:0])
                                     && (surf_q[c] == desc_q[c].surf_num[RPW-1:0]);
            src_addr_d[c] = src_line_q[c] + (AW'(off_q[c]) << ATOM_SHIFT);
            dst_addr_d[c] = dst_line_q[c] + (AW'(off_q[c]) << ATOM_SHIFT);
            src_line_nxt_d[c] = src_line_q[c] + AW'(atoms_to_bytes(desc_q[c].src_line_stride));
            src_surf_nxt_d[c] = src_surf_q[c] + AW'(atoms_to_bytes(desc_q[c].src_surf_stride));
            dst_line_nxt_d[c] = dst_line_q[c] + AW'(atoms_to_bytes(desc_q[c].dst_line_stride));
            dst_surf_nxt_d[c] = dst_surf_q[c] + AW'(atoms_to_bytes(desc_q[c].dst_surf_stride));
            elig_d[c]     = (state_q[c] == CH_ACTIVE) && !(stg_vld_q && (stg_ch == CW'(c)));
        end
    end

    always_comb begin
        cfg_ready = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            ch_idle[c]   = (state_q[c] == CH_IDLE);
            stall_inc[c] = stg_vld_q && !consume && (stg_ch == CW'(c));
            if (cfg_ch == CW'(c)) cfg_ready = (state_q[c] == CH_IDLE);
        end
    end

    always_comb begin
        cfg_desc_d                 = '0;
        cfg_desc_d.src_addr        = PKG_AW'(cfg_src_addr);
        cfg_desc_d.dst_addr        = PKG_AW'(cfg_dst_addr);
        cfg_desc_d.line_size       = PKG_LSW'(cfg_line_size);
        cfg_desc_d.line_num        = PKG_RPW'(cfg_line_num);
        cfg_desc_d.surf_num        = PKG_RPW'(cfg_surf_num);
        cfg_desc_d.src_line_stride = PKG_SW'(cfg_src_line_stride);
        cfg_desc_d.src_surf_stride = PKG_SW'(cfg_src_surf_stride);
        cfg_desc_d.dst_line_stride = PKG_SW'(cfg_dst_line_stride);
        cfg_desc_d.dst_surf_stride = PKG_SW'(cfg_dst_surf_stride);
    end

    nvdla_bdma_rr_arb #(
        .NCH (NCH),
        .CW  (CW)
    ) u_arb (
        .clk_i     (nvdla_core_clk),
        .rst_ni    (nvdla_core_rstn),
        .req_i     (elig_d),
        .adv_i     (load),
        .gnt_vld_o (gnt_vld),
        .gnt_idx_o (gnt_idx)
    );

    always_comb begin
        gnt_ctx_d          = '0;
        gnt_ctx_d.last     = last_d[gnt_idx];
        gnt_ctx_d.size_m1  = PKG_ZW'(size_d[gnt_idx] - ONE_L);
        gnt_ctx_d.dst_addr = PKG_AW'(dst_addr_d[gnt_idx]);
        gnt_ctx_d.ch       = PKG_CW'(gnt_idx);
        gnt_rd_pd_d        = {ZW'(size_d[gnt_idx] - ONE_L), src_addr_d[gnt_idx]};
    end

    // Channel FSMs and walkers
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            for (int c = 0; c < NCH; c++) begin
                state_q[c]    <= CH_IDLE;
                desc_q[c]     <= '0;
                off_q[c]      <= '0;
                line_q[c]     <= '0;
                surf_q[c]     <= '0;
                src_line_q[c] <= '0;
                src_surf_q[c] <= '0;
                dst_line_q[c] <= '0;
                dst_surf_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (cfg_acc && (cfg_ch == CW'(c))) begin
                    state_q[c]    <= CH_ACTIVE;
                    desc_q[c]     <= cfg_desc_d;
                    off_q[c]      <= '0;
                    line_q[c]     <= '0;
                    surf_q[c]     <= '0;
                    src_line_q[c] <= cfg_src_addr;
                    src_surf_q[c] <= cfg_src_addr;
                    dst_line_q[c] <= cfg_dst_addr;
                    dst_surf_q[c] <= cfg_dst_addr;
                end else if (state_q[c] == CH_ACTIVE) begin
                    if (consume && stg_ctx_q.last && (stg_ch == CW'(c)))
                        state_q[c] <= CH_IDLE;
                    // The final request leaves the walker parked until its consume.
                    if (load && (gnt_idx == CW'(c)) && !last_d[c]) begin
                        if (!eol_d[c]) begin
                            off_q[c] <= off_q[c] + LSW'(size_d[c]);
                        end else begin
                            off_q[c] <= '0;
                            if (line_q[c] == desc_q[c].line_num[RPW-1:0]) begin
                                line_q[c]     <= '0;
                                surf_q[c]     <= surf_q[c] + RPW'(1);
                                src_surf_q[c] <= src_surf_nxt_d[c];
                                src_line_q[c] <= src_surf_nxt_d[c];
                                dst_surf_q[c] <= dst_surf_nxt_d[c];
                                dst_line_q[c] <= dst_surf_nxt_d[c];
                            end else begin
                                line_q[c]     <= line_q[c] + RPW'(1);
                                src_line_q[c] <= src_line_nxt_d[c];
                                dst_line_q[c] <= dst_line_nxt_d[c];
                            end
                        end
                    end
                end
            end
        end
    end

    // Shared output stage
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            stg_vld_q   <= 1'b0;
            stg_rd_pd_q <= '0;
            stg_ctx_q   <= '0;
        end else if (load) begin
            stg_vld_q   <= 1'b1;
            stg_rd_pd_q <= gnt_rd_pd_d;
            stg_ctx_q   <= gnt_ctx_d;
        end else if (consume) begin
            stg_vld_q   <= 1'b0;
        end
    end

    assign rd_req_valid = stg_vld_q;
    assign ld2st_valid  = stg_vld_q;
    assign rd_req_pd    = stg_rd_pd_q;
    assign ld2st_pd     = {stg_ctx_q.last, stg_ctx_q.size_m1[ZW-1:0],
                           stg_ctx_q.dst_addr[AW-1:0], stg_ctx_q.ch[CW-1:0]};

    // Bits of the wide package structs that this configuration never reads.
    always_comb begin
        unused_bits = ^stg_ctx_q;
        for (int c = 0; c < NCH; c++) unused_bits = unused_bits ^ (^desc_q[c]);
    end

endmodule

// File: tb/tb_nvdla_bdma_mc_load.sv
// Directed bench for nvdla_bdma_mc_load with default parameters (NCH=2, MAX_BURST=8).
module tb_nvdla_bdma_mc_load;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic        cfg_valid, cfg_ready;
    logic [0:0]  cfg_ch;
    logic [63:0] cfg_src_addr, cfg_dst_addr;
    logic [12:0] cfg_line_size;
    logic [23:0] cfg_line_num, cfg_surf_num;
    logic [26:0] cfg_src_line_stride, cfg_src_surf_stride;
    logic [26:0] cfg_dst_line_stride, cfg_dst_surf_stride;
    logic        rd_req_valid, rd_req_ready;
    logic [66:0] rd_req_pd;
    logic        ld2st_valid, ld2st_ready;
    logic [68:0] ld2st_pd;
    logic [1:0]  ch_idle, stall_inc;

    int          n_assert = 0;
    int          n_fail   = 0;

    logic [63:0] r_addr, r_dst;
    int          r_sz, r_lsz, r_wait;
    logic        r_last, r_ch, r_crdy;
    logic [1:0]  r_stall;

    logic [63:0] exp36 [6] = '{64'h0, 64'h400, 64'h800, 64'h10000, 64'h10400, 64'h10800};

    always #5 clk = ~clk;

    nvdla_bdma_mc_load dut (
        .nvdla_core_clk      (clk),
        .nvdla_core_rstn     (rstn),
        .cfg_valid           (cfg_valid),
        .cfg_ready           (cfg_ready),
        .cfg_ch              (cfg_ch),
        .cfg_src_addr        (cfg_src_addr),
        .cfg_dst_addr        (cfg_dst_addr),
        .cfg_line_size       (cfg_line_size),
        .cfg_line_num        (cfg_line_num),
        .cfg_surf_num        (cfg_surf_num),
        .cfg_src_line_stride (cfg_src_line_stride),
        .cfg_src_surf_stride (cfg_src_surf_stride),
        .cfg_dst_line_stride (cfg_dst_line_stride),
        .cfg_dst_surf_stride (cfg_dst_surf_stride),
        .rd_req_valid        (rd_req_valid),
        .rd_req_ready        (rd_req_ready),
        .rd_req_pd           (rd_req_pd),
        .ld2st_valid         (ld2st_valid),
        .ld2st_ready         (ld2st_ready),
        .ld2st_pd            (ld2st_pd),
        .ch_idle             (ch_idle),
        .stall_inc           (stall_inc)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_cfg(input logic ch, input logic [63:0] src, input logic [63:0] dst,
                            input int ls, input int ln, input int sn,
                            input int sls, input int sss, input int dls, input int dss);
        logic acc;
        int   w;
        cfg_ch = ch; cfg_src_addr = src; cfg_dst_addr = dst;
        cfg_line_size = 13'(ls); cfg_line_num = 24'(ln); cfg_surf_num = 24'(sn);
        cfg_src_line_stride = 27'(sls); cfg_src_surf_stride = 27'(sss);
        cfg_dst_line_stride = 27'(dls); cfg_dst_surf_stride = 27'(dss);
        cfg_valid = 1'b1;
        acc = 1'b0; w = 0;
        while (!acc && w < 50) begin
            @(negedge clk);
            if (cfg_ready) acc = 1'b1; else w++;
        end
        chk("cfg_accept", acc, 1'b1);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic get_req();
        int   w;
        logic got;
        w = 0; got = 1'b0;
        while (!got && w < 100) begin
            @(negedge clk);
            if (rd_req_valid && rd_req_ready && ld2st_ready) got = 1'b1; else w++;
        end
        chk("req_seen", got, 1'b1);
        r_wait  = w;
        r_addr  = rd_req_pd[63:0];
        r_sz    = int'(rd_req_pd[66:64]) + 1;
        r_ch    = ld2st_pd[0];
        r_dst   = ld2st_pd[64:1];
        r_lsz   = int'(ld2st_pd[67:65]) + 1;
        r_last  = ld2st_pd[68];
        r_crdy  = cfg_ready;
        r_stall = stall_inc;
        @(posedge clk); #1;
    endtask

    task automatic exp_req(input string tag, input logic [63:0] a, input int sz, input logic lst,
                           input logic ch, input logic [63:0] d);
        get_req();
        chk({tag, "_addr"}, r_addr, a);
        chk({tag, "_size"}, r_sz, sz);
        chk({tag, "_lsize"}, r_lsz, sz);
        chk({tag, "_last"}, r_last, lst);
        chk({tag, "_ch"}, r_ch, ch);
        chk({tag, "_dst"}, r_dst, d);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rd_valid"}, rd_req_valid, 1'b0);
        chk({tag, "_ld_valid"}, ld2st_valid, 1'b0);
        chk({tag, "_idle"}, ch_idle, 2'b11);
        chk({tag, "_stall"}, stall_inc, 2'b00);
        chk({tag, "_rd_pd"}, rd_req_pd, 67'h0);
        chk({tag, "_ld_pd"}, ld2st_pd, 69'h0);
    endtask

    task automatic run_basic(input string tag);
        send_cfg(1'b0, 64'h1000, 64'h8000, 19, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk({tag, "_T1_valid"}, rd_req_valid, 1'b0);
        exp_req({tag, "_r0"}, 64'h1000, 8, 1'b0, 1'b0, 64'h8000);
        chk({tag, "_latency"}, r_wait, 0);
        exp_req({tag, "_r1"}, 64'h1100, 8, 1'b0, 1'b0, 64'h8100);
        exp_req({tag, "_r2"}, 64'h1200, 4, 1'b1, 1'b0, 64'h8200);
        chk({tag, "_cfg_rdy_at_done"}, r_crdy, 1'b0);
        @(negedge clk);
        chk({tag, "_idle_after"}, ch_idle, 2'b11);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [66:0] hold_rd;
        logic [68:0] hold_ld;
        int          nstall;

        cfg_valid = 1'b0; cfg_ch = 1'b0;
        cfg_src_addr = '0; cfg_dst_addr = '0; cfg_line_size = '0;
        cfg_line_num = '0; cfg_surf_num = '0;
        cfg_src_line_stride = '0; cfg_src_surf_stride = '0;
        cfg_dst_line_stride = '0; cfg_dst_surf_stride = '0;
        rd_req_ready = 1'b1; ld2st_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        chk("por_cfg_ready", cfg_ready, 1'b1);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        // Single channel, 20-atom line split 8/8/4
        run_basic("basic");

        // Two long descriptors interleave one request per cycle
        send_cfg(1'b0, 64'h10000, 64'h50000, 100, 0, 0, 0, 0, 0, 0);
        send_cfg(1'b1, 64'h20000, 64'h60000, 100, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            exp_req($sformatf("rr%0d", k),
                    ((k % 2) == 0 ? 64'h10000 : 64'h20000) + 64'(k / 2) * 64'h100, 8, 1'b0,
                    1'(k % 2),
                    ((k % 2) == 0 ? 64'h50000 : 64'h60000) + 64'(k / 2) * 64'h100);
            chk($sformatf("rr%0d_back_to_back", k), r_wait, 0);
        end

        // Store side back-pressure for ten cycles
        ld2st_ready = 1'b0;
        nstall = 0;
        @(negedge clk);
        hold_rd = rd_req_pd;
        hold_ld = ld2st_pd;
        chk("hold_addr", rd_req_pd[63:0], 64'h10300);
        chk("hold_ch", ld2st_pd[0], 1'b0);
        chk("busy_idle", ch_idle, 2'b00);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            chk("hold_rd_valid", rd_req_valid, 1'b1);
            chk("hold_ld_valid", ld2st_valid, 1'b1);
            chk("hold_rd_pd", rd_req_pd, hold_rd);
            chk("hold_ld_pd", ld2st_pd, hold_ld);
            chk("hold_stall", stall_inc, 2'b01);
            if (stall_inc[0]) nstall++;
            @(posedge clk); #1;
            if (k == 0) begin
                cfg_ch = 1'b0; cfg_valid = 1'b1;
                #1 chk("busy_cfg_ready", cfg_ready, 1'b0);
            end
        end
        cfg_valid = 1'b0;
        chk("stall_count", nstall, 10);
        ld2st_ready = 1'b1;
        exp_req("release", 64'h10300, 8, 1'b0, 1'b0, 64'h50300);
        chk("release_wait", r_wait, 0);
        chk("release_stall", r_stall, 2'b00);

        // Reset in the middle of both transfers
        chk("pre_reset_valid", rd_req_valid, 1'b1);
        rstn = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;

        // One-atom lines across two surfaces
        send_cfg(1'b1, 64'h0, 64'h40000, 0, 2, 1, 32'h20, 32'h800, 32'h20, 32'h800);
        for (int k = 0; k < 6; k++)
            exp_req($sformatf("surf%0d", k), exp36[k], 1, 1'(k == 5), 1'b1, exp36[k] + 64'h40000);
        @(negedge clk);
        chk("surf_idle_after", ch_idle, 2'b11);
        @(posedge clk); #1;

        // Address wrap at the top of the 64-bit space
        send_cfg(1'b0, 64'hFFFF_FFFF_FFFF_FFE0, 64'h0, 0, 1, 0, 1, 0, 1, 0);
        exp_req("wrap0", 64'hFFFF_FFFF_FFFF_FFE0, 1, 1'b0, 1'b0, 64'h0);
        exp_req("wrap1", 64'h0, 1, 1'b1, 1'b0, 64'h20);

        // Reset right after the first request, then a clean replay
        send_cfg(1'b0, 64'h1000, 64'h8000, 19, 0, 0, 0, 0, 0, 0);
        exp_req("pre_rst_r0", 64'h1000, 8, 1'b0, 1'b0, 64'h8000);
        rstn = 1'b0;
        #1;
        check_reset_outputs("rst2");
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;
        run_basic("replay");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
